// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_pkg
// Purpose  : Shared definitions for the register-file dump engine: FSM state
//            encoding, default geometry and the index helper functions.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_dump_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_LOAD = 2'd1;
    localparam state_t c_SEND = 2'd2;

    // Next register index, wrapping from the last register back to 0.
    function automatic logic [31:0] inc_wrap(input logic [31:0] i, input int unsigned n);
        return (i == n - 1) ? 32'd0 : i + 32'd1;
    endfunction

    // Out-of-range indices are pinned to the last register.
    function automatic logic [31:0] clamp_idx(input logic [31:0] i, input int unsigned n);
        return (i >= n) ? n - 1 : i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_idx.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_idx
// Purpose  : Wrapping register-index counter for the dump engine. Holds the
//            current index and the final index of the range, both clamped to
//            the register count when loaded.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            i_load             - capture clamped start/end indices
//            i_inc_en           - advance current index (wraps at NUM_REGS-1)
//            i_start_idx/i_end_idx - raw range bounds
//            o_start_clamped    - clamped i_start_idx (combinational)
//            o_idx, o_idx_inc   - current index and its wrapped successor
//            o_at_end           - current index equals final index
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_idx
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_inc_en,
    input  logic [ADDR_W-1:0] i_start_idx,
    input  logic [ADDR_W-1:0] i_end_idx,
    output logic [ADDR_W-1:0] o_start_clamped,
    output logic [ADDR_W-1:0] o_idx,
    output logic [ADDR_W-1:0] o_idx_inc,
    output logic              o_at_end
);

    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_end;
    logic [ADDR_W-1:0] w_end_clamped;

    assign o_start_clamped = ADDR_W'(clamp_idx(32'(i_start_idx), NUM_REGS));
    assign w_end_clamped   = ADDR_W'(clamp_idx(32'(i_end_idx), NUM_REGS));
    assign o_idx_inc       = ADDR_W'(inc_wrap(32'(r_idx), NUM_REGS));
    assign o_idx           = r_idx;
    assign o_at_end        = (r_idx == r_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_end <= '0;
        end else if (i_load) begin
            r_idx <= o_start_clamped;
            r_end <= w_end_clamped;
        end else if (i_inc_en) begin
            r_idx <= o_idx_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Purpose  : Walks a contiguous (possibly wrapping) range of registers through
//            one register-file read port and streams each value out on a
//            valid/ready interface with backpressure.
// Ports    : clock, ctrl_reset      - clock, synchronous active-low reset
//            start, abort           - launch / terminate a dump
//            start_idx, end_idx     - range bounds, sampled with start
//            rd_addr, rd_data       - combinational register-file read port
//            out_valid, out_ready   - output handshake
//            out_data, out_index    - captured value and its index
//            busy                   - dump in progress (LOAD or SEND)
//            done                   - one-cycle pulse after final beat
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_idx,
    input  logic [ADDR_W-1:0] end_idx,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_index;
    logic              r_done;

    logic              w_rst;
    logic              w_load_idx;
    logic              w_inc_en;
    logic              w_cap_en;
    logic              w_done_set;
    logic [ADDR_W-1:0] w_cap_index;
    logic [ADDR_W-1:0] w_start_clamped;
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_idx_inc;
    logic              w_at_end;

    assign w_rst = ~ctrl_reset;

    regfile_dump_idx #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_idx (
        .clk             (clock),
        .rst             (w_rst),
        .i_load          (w_load_idx),
        .i_inc_en        (w_inc_en),
        .i_start_idx     (start_idx),
        .i_end_idx       (end_idx),
        .o_start_clamped (w_start_clamped),
        .o_idx           (w_idx),
        .o_idx_inc       (w_idx_inc),
        .o_at_end        (w_at_end)
    );

    // In SEND the read port already looks one register ahead so the next
    // beat can be captured on the same edge the current one is accepted.
    always_comb begin
        w_next_state = r_state;
        w_load_idx   = 1'b0;
        w_inc_en     = 1'b0;
        w_cap_en     = 1'b0;
        w_done_set   = 1'b0;
        rd_addr      = w_start_clamped;
        case (r_state)
            c_IDLE: begin
                rd_addr = w_start_clamped;
                if (start) begin
                    w_load_idx   = 1'b1;
                    w_next_state = c_LOAD;
                end
            end
            c_LOAD: begin
                rd_addr = w_idx;
                if (abort) begin
                    w_next_state = c_IDLE;
                end else begin
                    w_cap_en     = 1'b1;
                    w_next_state = c_SEND;
                end
            end
            c_SEND: begin
                rd_addr = w_idx_inc;
                // abort wins over completion so an aborted dump never pulses done.
                if (abort) begin
                    w_next_state = c_IDLE;
                end else if (out_ready) begin
                    if (w_at_end) begin
                        w_next_state = c_IDLE;
                        w_done_set   = 1'b1;
                    end else begin
                        w_inc_en = 1'b1;
                        w_cap_en = 1'b1;
                    end
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    assign w_cap_index = (r_state == c_LOAD) ? w_idx : w_idx_inc;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            r_state <= c_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_set;
        end
    end

    // Enable-gated capture register: holds the beat stable under backpressure.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            r_data  <= '0;
            r_index <= '0;
        end else if (w_cap_en) begin
            r_data  <= rd_data;
            r_index <= w_cap_index;
        end
    end

    assign out_valid = (r_state == c_SEND);
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;
    assign out_data  = r_data;
    assign out_index = r_index;

endmodule
`default_nettype wire
